uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets N_REQ requesters share one uart_tx character port.
// A grant is issued only from IDLE while uart_tx reports ready, then the block tracks the ready handshake.
module uart_tx_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]              req_ready,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic                          busy,
   output logic [15:0]                   sent_cnt
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   state_t                  state_q;
   logic [IW-1:0]           ptr_q;
   logic [1:0]              wait_q;
   logic [DATA_WIDTH-1:0]   tx_data_q;
   logic [IW-1:0]           grant_id_q;
   logic                    tx_valid_q;
   logic [N_REQ-1:0]        req_ready_q;
   logic                    busy_q;
   logic [15:0]             sent_cnt_q;

   logic                    win_found_d;
   logic [IW-1:0]           win_idx_d;
   logic [IW:0]             scan_sum_d;
   logic [IW-1:0]           scan_idx_d;
   logic [IW-1:0]           ptr_d;
   logic [DATA_WIDTH-1:0]   win_data_d;
   logic [N_REQ-1:0]        win_onehot_d;

   // Rotating priority search: first valid index starting at ptr_q, wrapping modulo N_REQ
   always_comb begin
      win_found_d = 1'b0;
      win_idx_d   = '0;
      scan_sum_d  = '0;
      scan_idx_d  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_sum_d  = {1'b0, ptr_q} + (IW+1)'(k);
         scan_sum_d  = (scan_sum_d >= (IW+1)'(N_REQ)) ? scan_sum_d - (IW+1)'(N_REQ) : scan_sum_d;
         scan_idx_d  = scan_sum_d[IW-1:0];
         win_idx_d   = (req_valid[scan_idx_d] && !win_found_d) ? scan_idx_d : win_idx_d;
         win_found_d = win_found_d | req_valid[scan_idx_d];
      end
   end

   // Winner payload, one-hot acknowledge and the pointer that follows the winner
   always_comb begin
      win_data_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
         win_data_d = (win_idx_d == IW'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : win_data_d;
      end
      win_onehot_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_d;
      if (win_idx_d == IW'(N_REQ-1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = win_idx_d + IW'(1);
      end
   end

   // Arbitration FSM; every output is a register updated here
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         wait_q      <= 2'd0;
         tx_data_q   <= '0;
         grant_id_q  <= '0;
         tx_valid_q  <= 1'b0;
         req_ready_q <= '0;
         busy_q      <= 1'b0;
         sent_cnt_q  <= 16'd0;
      end else begin
         tx_valid_q  <= 1'b0;
         req_ready_q <= '0;
         case (state_q)
            IDLE: begin
               // sent_cnt steps with the grant so it already counts the character while tx_valid is high
               if (tx_ready && win_found_d) begin
                  state_q     <= ISSUE;
                  tx_data_q   <= win_data_d;
                  grant_id_q  <= win_idx_d;
                  ptr_q       <= ptr_d;
                  tx_valid_q  <= 1'b1;
                  req_ready_q <= win_onehot_d;
                  busy_q      <= 1'b1;
                  sent_cnt_q  <= sent_cnt_q + 16'd1;
               end else begin
                  busy_q      <= 1'b0;
               end
            end
            ISSUE: begin
               state_q <= WAIT_LOW;
               wait_q  <= 2'd0;
            end
            WAIT_LOW: begin
               if (!tx_ready) begin
                  state_q <= WAIT_HIGH;
               end else if (wait_q == 2'd3) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  wait_q  <= wait_q + 2'd1;
               end
            end
            WAIT_HIGH: begin
               if (tx_ready) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= WAIT_HIGH;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign grant_id  = grant_id_q;
   assign busy      = busy_q;
   assign sent_cnt  = sent_cnt_q;

endmodule
